// File: rtl/entropy_pkg.sv
// Shared types and constants for the entropy source.
// Build option: ENTROPY_VN_DEBIAS_EN selects von Neumann pair extraction.
package entropy_pkg;

  typedef enum logic {
    PAIR_EMPTY = 1'b0,
    PAIR_HALF  = 1'b1
  } pair_state_e;

  localparam int DEF_SAMPLE_DIV  = 4;
  localparam int DEF_WORD_W      = 8;
  localparam int DEF_STALL_LIMIT = 64;
  localparam int STALL_W         = 16;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-state of the two synchronizer stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/entropy_source.sv
// Entropy source: samples synchronized raw noise on a divided strobe, debiases,
// emits per-bit pulses and assembles bits into words with valid/ready.
// Build option: ENTROPY_VN_DEBIAS_EN enables von Neumann pair extraction;
// undefined, every strobe emits the sample directly.
//
// state      | meaning
// PAIR_EMPTY | waiting for the first sample of a pair
// PAIR_HALF  | first sample held in a_q, waiting for the second
module entropy_source
  import entropy_pkg::*;
#(
  parameter int SAMPLE_DIV  = DEF_SAMPLE_DIV,
  parameter int WORD_W      = DEF_WORD_W,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              raw_noise,
  input  logic              enable,
  output logic              entropy_bit,
  output logic              entropy_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              stuck
);

  localparam int                 BIT_W    = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [7:0]         DIV_LAST = 8'(SAMPLE_DIV - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(WORD_W - 1);
  localparam logic [STALL_W-1:0] LIMIT    = STALL_W'(STALL_LIMIT);

  logic sample;

  logic [7:0]         div_q, div_d;
  logic               strobe;
  logic               a_q, a_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               stuck_q, stuck_d;
  logic               emit;
  logic               emit_bit;

  logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0]  shift_q, shift_d;
  logic [WORD_W-1:0]  wout_q, wout_d;
  logic [WORD_W-1:0]  full_word;
  logic               wvld_q, wvld_d;
  logic               ev_q, ev_d;
  logic               eb_q, eb_d;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (raw_noise),
    .q     (sample)
  );

  // Sample divider: strobe on the cycle the count wraps back to 0.
  always_comb begin
    div_d  = div_q;
    strobe = 1'b0;
    if (!enable) begin
      div_d = '0;
    end else if (div_q == DIV_LAST) begin
      div_d  = '0;
      strobe = 1'b1;
    end else begin
      div_d = div_q + 8'd1;
    end
  end

`ifdef ENTROPY_VN_DEBIAS_EN
  pair_state_e state_q, state_d;

  // Pair FSM next state, bit extraction and stall counting over discarded pairs.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    stall_d  = stall_q;
    emit     = 1'b0;
    emit_bit = a_q;
    if (!enable) begin
      state_d = PAIR_EMPTY;
      a_d     = 1'b0;
      stall_d = '0;
    end else if (strobe) begin
      case (state_q)
        PAIR_EMPTY: begin
          a_d     = sample;
          state_d = PAIR_HALF;
        end
        PAIR_HALF: begin
          state_d = PAIR_EMPTY;
          if (a_q != sample) begin
            emit     = 1'b1;
            emit_bit = a_q;
            stall_d  = '0;
          end else if (stall_q != '1) begin
            stall_d = stall_q + STALL_W'(1);
          end
        end
      endcase
    end
  end

  // Pair FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= PAIR_EMPTY;
    else      state_q <= state_d;
  end
`else
  logic prev_vld_q, prev_vld_d;

  // Direct emission; stall counts samples repeating the previous one.
  always_comb begin
    a_d        = a_q;
    prev_vld_d = prev_vld_q;
    stall_d    = stall_q;
    emit       = 1'b0;
    emit_bit   = a_q;
    if (!enable) begin
      a_d        = 1'b0;
      prev_vld_d = 1'b0;
      stall_d    = '0;
    end else if (strobe) begin
      emit       = 1'b1;
      emit_bit   = sample;
      a_d        = sample;
      prev_vld_d = 1'b1;
      if (prev_vld_q && (sample == a_q)) begin
        if (stall_q != '1) stall_d = stall_q + STALL_W'(1);
      end else begin
        stall_d = '0;
      end
    end
  end

  // Previous-sample valid flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_vld_q <= 1'b0;
    else      prev_vld_q <= prev_vld_d;
  end
`endif

  // Sticky stuck flag, cleared only while halted.
  always_comb begin
    stuck_d = enable & (stuck_q | (stall_d >= LIMIT));
  end

  // Word assembly, single-entry output holding register and handshake.
  always_comb begin
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    wout_d    = wout_q;
    wvld_d    = wvld_q;
    ev_d      = emit;
    eb_d      = emit ? emit_bit : eb_q;
    full_word = {shift_q[WORD_W-2:0], emit_bit};
    if (wvld_q && word_ready) wvld_d = 1'b0;
    if (!enable) begin
      bitcnt_d = '0;
      shift_d  = '0;
    end else if (emit) begin
      shift_d = full_word;
      if (bitcnt_q == BIT_LAST) begin
        bitcnt_d = '0;
        // A pending word that is not leaving this cycle wins; the new one drops.
        if (!wvld_q || word_ready) begin
          wout_d = full_word;
          wvld_d = 1'b1;
        end
      end else begin
        bitcnt_d = bitcnt_q + BIT_W'(1);
      end
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      a_q      <= 1'b0;
      stall_q  <= '0;
      stuck_q  <= 1'b0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      wout_q   <= '0;
      wvld_q   <= 1'b0;
      ev_q     <= 1'b0;
      eb_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      a_q      <= a_d;
      stall_q  <= stall_d;
      stuck_q  <= stuck_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      wout_q   <= wout_d;
      wvld_q   <= wvld_d;
      ev_q     <= ev_d;
      eb_q     <= eb_d;
    end
  end

  assign entropy_bit   = eb_q;
  assign entropy_valid = ev_q;
  assign word_out      = wout_q;
  assign word_valid    = wvld_q;
  assign stuck         = stuck_q;

endmodule

// File: tb/tb_entropy_source.sv
// Testbench for entropy_source: sample-level behavioural model plus
// directed scenarios with literal expectations.
module tb_entropy_source;

  localparam int DIV   = 4;
  localparam int W     = 8;
  localparam int LIMIT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         raw_noise;
  logic         enable;
  logic         entropy_bit;
  logic         entropy_valid;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         word_ready;
  logic         stuck;

  int checks = 0;
  int errors = 0;

  entropy_source #(
    .SAMPLE_DIV  (DIV),
    .WORD_W      (W),
    .STALL_LIMIT (LIMIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .raw_noise     (raw_noise),
    .enable        (enable),
    .entropy_bit   (entropy_bit),
    .entropy_valid (entropy_valid),
    .word_out      (word_out),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .stuck         (stuck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Sample seen at an edge is raw_noise from two edges earlier; strobes fall
  // on every DIV-th consecutive enabled edge.
  bit         hist[$];
  int         m_run;
  bit         m_samp[$];
  int         m_disc;
  bit         m_have_prev, m_prev;
  bit         m_stuck, m_ev, m_eb, m_wvld;
  logic [W-1:0] m_wout;
  bit         m_bits[$];

  always @(posedge clk) begin : model
    bit smp, strobe, emit, ebit, old;
    logic [W-1:0] w;
    if (!rst) begin
      hist = {1'b0, 1'b0, 1'b0};
      m_run = 0; m_samp.delete(); m_disc = 0; m_have_prev = 0; m_prev = 0;
      m_stuck = 0; m_ev = 0; m_eb = 0; m_wvld = 0; m_wout = '0; m_bits.delete();
    end else begin
      hist.push_front(raw_noise);
      void'(hist.pop_back());
      smp    = hist[2];
      m_run  = enable ? m_run + 1 : 0;
      strobe = enable && (m_run % DIV == 0);
      emit   = 0;
      ebit   = 0;
      if (!enable) begin
        m_samp.delete(); m_disc = 0; m_stuck = 0; m_bits.delete(); m_have_prev = 0;
      end else if (strobe) begin
`ifdef ENTROPY_VN_DEBIAS_EN
        m_samp.push_back(smp);
        if (m_samp.size() == 2) begin
          if (m_samp[0] != m_samp[1]) begin
            emit = 1; ebit = m_samp[0]; m_disc = 0;
          end else if (m_disc < 65535) m_disc++;
          m_samp.delete();
        end
`else
        emit = 1; ebit = smp;
        if (m_have_prev && smp == m_prev) begin
          if (m_disc < 65535) m_disc++;
        end else m_disc = 0;
        m_have_prev = 1; m_prev = smp;
`endif
        if (m_disc >= LIMIT) m_stuck = 1;
      end
      m_ev = emit;
      if (emit) m_eb = ebit;
      old = m_wvld;
      if (old && word_ready) m_wvld = 0;
      if (emit) begin
        m_bits.push_back(ebit);
        if (m_bits.size() == W) begin
          w = '0;
          for (int i = 0; i < W; i++) w = {w[W-2:0], m_bits[i]};
          m_bits.delete();
          if (!old || word_ready) begin
            m_wout = w; m_wvld = 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_entropy_valid", entropy_valid, 0);
      chk("rst_entropy_bit", entropy_bit, 0);
      chk("rst_word_valid", word_valid, 0);
      chk("rst_word_out", word_out, 0);
      chk("rst_stuck", stuck, 0);
    end else begin
      chk("entropy_valid", entropy_valid, m_ev);
      if (m_ev) chk("entropy_bit", entropy_bit, m_eb);
      chk("word_valid", word_valid, m_wvld);
      chk("word_out", word_out, m_wout);
      chk("stuck", stuck, m_stuck);
    end
  end

  // Record emitted bits for literal checks.
  bit got_bits[$];
  int pulses = 0;
  always @(negedge clk) begin
    if (rst && entropy_valid) begin
      got_bits.push_back(entropy_bit);
      pulses++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One raw sample held for a full strobe period; optional ready at its strobe edge.
  task automatic feed_sample(input bit b, input bit rdy);
    raw_noise = b;
    tick(DIV - 1);
    if (rdy) word_ready = 1'b1;
    tick(1);
    if (rdy) word_ready = 1'b0;
  endtask

  task automatic feed_bit(input bit b, input bit rdy);
`ifdef ENTROPY_VN_DEBIAS_EN
    feed_sample(b, 1'b0);
    feed_sample(!b, rdy);
`else
    feed_sample(b, rdy);
`endif
  endtask

  task automatic feed_word(input logic [W-1:0] wv, input bit rdy_last);
    for (int i = W - 1; i >= 0; i--) feed_bit(wv[i], rdy_last && (i == 0));
  endtask

  task automatic take_word();
    word_ready = 1'b1;
    tick(1);
    word_ready = 1'b0;
    chk("take_word_valid_clear", word_valid, 0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int n;
    bit pat[$];
    rst = 1'b1; enable = 1'b0; raw_noise = 1'b0; word_ready = 1'b0;
    #2 rst = 1'b0;
    tick(5);
    chk("reset_lit_entropy_valid", entropy_valid, 0);
    chk("reset_lit_word_valid", word_valid, 0);
    chk("reset_lit_word_out", word_out, 0);
    chk("reset_lit_stuck", stuck, 0);

    rst = 1'b1;
    tick(20);
    chk("halt_no_pulses", pulses, 0);

    // Basic extraction
    got_bits.delete();
    enable = 1'b1;
`ifdef ENTROPY_VN_DEBIAS_EN
    pat = {1'b1,1'b0, 1'b0,1'b1, 1'b1,1'b1, 1'b0,1'b0, 1'b1,1'b0};
    foreach (pat[i]) feed_sample(pat[i], 1'b0);
    tick(2);
    chk("basic_pulse_count", got_bits.size(), 3);
    chk("basic_bit0", got_bits[0], 1);
    chk("basic_bit1", got_bits[1], 0);
    chk("basic_bit2", got_bits[2], 1);
`else
    pat = {1'b1, 1'b0, 1'b1, 1'b0};
    foreach (pat[i]) feed_sample(pat[i], 1'b0);
    tick(2);
    chk("toggle_pulse_count", got_bits.size(), 4);
    chk("toggle_bit0", got_bits[0], 1);
    chk("toggle_bit1", got_bits[1], 0);
    chk("toggle_bit2", got_bits[2], 1);
    chk("toggle_bit3", got_bits[3], 0);
`endif
    enable = 1'b0;
    tick(2);

    // Word handshake
    enable = 1'b1;
    feed_word(8'hB2, 1'b0);
    enable = 1'b0;
    tick(3);
    chk("word_b2_out", word_out, 8'hB2);
    chk("word_b2_valid_held", word_valid, 1);
    take_word();

    // Overflow: second word lost while the first is pending
    got_bits.delete();
    enable = 1'b1;
    feed_word(8'h3C, 1'b0);
    feed_word(8'hE7, 1'b0);
    enable = 1'b0;
    tick(2);
    chk("ovf_pulses_16", got_bits.size(), 16);
    chk("ovf_word_out_first", word_out, 8'h3C);
    chk("ovf_word_valid", word_valid, 1);
    take_word();
    tick(2);
    chk("ovf_second_lost", word_valid, 0);

    // Completion coinciding with handshake keeps valid high with the new word
    enable = 1'b1;
    feed_word(8'h5A, 1'b0);
    feed_word(8'hC3, 1'b1);
    enable = 1'b0;
    tick(2);
    chk("simul_word_out_new", word_out, 8'hC3);
    chk("simul_word_valid", word_valid, 1);
    take_word();

    // Ready held high continuously
    word_ready = 1'b1;
    enable = 1'b1;
    feed_word(8'h96, 1'b0);
    enable = 1'b0;
    tick(2);
    chk("ready_high_valid_low", word_valid, 0);
    chk("ready_high_word_out", word_out, 8'h96);
    word_ready = 1'b0;

    // Asynchronous reset mid-word discards partial state
    enable = 1'b1;
    feed_bit(1'b1, 1'b0);
    feed_bit(1'b1, 1'b0);
    feed_bit(1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_word_out", word_out, 0);
    chk("async_rst_stuck", stuck, 0);
    tick(2);
    enable = 1'b0;
    rst = 1'b1;
    tick(2);
    enable = 1'b1;
    feed_word(8'h81, 1'b0);
    enable = 1'b0;
    tick(2);
    chk("post_rst_word_out", word_out, 8'h81);
    chk("post_rst_word_valid", word_valid, 1);
    take_word();

    // Stuck detection with a constant source
    raw_noise = 1'b1;
    enable = 1'b1;
    chk("stuck_clear_at_start", stuck, 0);
    n = 0;
    while (n < 60) begin
      tick(1);
      n++;
      if (stuck) break;
    end
    chk("stuck_set", stuck, 1);
    chk("stuck_latency_ok", (n <= 8 * DIV + 3), 1);
    feed_bit(1'b1, 1'b0);
    feed_bit(1'b0, 1'b0);
    feed_bit(1'b1, 1'b0);
    feed_bit(1'b0, 1'b0);
    chk("stuck_sticky", stuck, 1);
    enable = 1'b0;
    tick(1);
    chk("stuck_cleared_by_halt", stuck, 0);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
